// File: rtl/fpu_issue_if.sv
// Issue and writeback handshake bundle between decode, fpu_issue_ctrl and writeback.
//   in_*  : decode -> controller issue channel (in_ready driven by controller)
//   out_* : controller -> writeback channel (out_ready driven by writeback)
// master: decode/writeback side; slave: fpu_issue_ctrl.
interface fpu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_flags
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for a combinational FP ALU: accepts one op at a time, holds
// registered operands on the ALU for a per-op settle latency, captures the
// result and presents it on a valid/ready writeback port.
//   CLK, RESET_N          : clock, async active-low reset
//   io (slave)            : issue handshake in, writeback handshake out
//   falu_op/a/b           : registered drive to the FP ALU (op 4'hF when idle)
//   falu_result/exc/ovf/unf : FP ALU outputs, sampled only at capture
//   flush                 : kills the in-flight op (ignored when idle)
//   flags_clr             : clears sticky_flags
//   sticky_flags          : accumulated {exc,ovf,unf} of completed ops
//   busy                  : controller not idle
//   op_count              : number of completed writeback handshakes
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_DIV = 6
) (
    input  logic        CLK,
    input  logic        RESET_N,
    fpu_issue_if.slave  io,
    output logic [3:0]  falu_op,
    output logic [31:0] falu_a,
    output logic [31:0] falu_b,
    input  logic [31:0] falu_result,
    input  logic        falu_exc,
    input  logic        falu_ovf,
    input  logic        falu_unf,
    input  logic        flush,
    input  logic        flags_clr,
    output logic [2:0]  sticky_flags,
    output logic        busy,
    output logic [31:0] op_count
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OP_W-1:0]   OP_IDLE   = 4'hF;
    localparam logic [FLAG_W-1:0] FLAGS_ILL = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [OP_W-1:0]     op_d;
    logic [DATA_W-1:0]   a_d, b_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                valid_d;
    logic [DATA_W-1:0]   result_d;
    logic [RD_W-1:0]     out_rd_d;
    logic [FLAG_W-1:0]   flags_d;
    logic [FLAG_W-1:0]   sticky_d;
    logic [DATA_W-1:0]   count_d;
    logic                in_ready_c;
    logic                accept_c;
    logic                hs_c;
    logic                flush_c;

    // Settle latency minus one, loaded into cnt on accept; illegal ops settle in one cycle.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_W-1:0] op);
        case (op)
            4'd0, 4'd1: return CNT_W'(LAT_ADD - 1);
            4'd2:       return CNT_W'(LAT_MUL - 1);
            4'd3:       return CNT_W'(LAT_DIV - 1);
            default:    return '0;
        endcase
    endfunction

    assign io.in_ready = in_ready_c;
    assign busy        = (state != IDLE);

    // Next-state and next-value logic.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        op_d       = falu_op;
        a_d        = falu_a;
        b_d        = falu_b;
        rd_d       = rd_q;
        valid_d    = io.out_valid;
        result_d   = io.out_result;
        out_rd_d   = io.out_rd;
        flags_d    = io.out_flags;
        sticky_d   = sticky_flags;
        count_d    = op_count;
        in_ready_c = 1'b0;
        accept_c   = 1'b0;
        hs_c       = 1'b0;
        flush_c    = flush && (state != IDLE);

        case (state)
            IDLE:    in_ready_c = 1'b1;
            DONE:    in_ready_c = io.out_ready;
            default: in_ready_c = 1'b0;
        endcase

        if (flush_c) begin
            // Flush overrides everything: drop the op, no accept, no bookkeeping.
            state_d = IDLE;
            valid_d = 1'b0;
            op_d    = OP_IDLE;
            cnt_d   = '0;
        end else begin
            hs_c     = (state == DONE) && io.out_ready;
            accept_c = io.in_valid && in_ready_c;

            if (state == EXEC) begin
                if (cnt == '0) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    out_rd_d = rd_q;
                    if (falu_op[3:2] != 2'b00) begin
                        result_d = '0;
                        flags_d  = FLAGS_ILL;
                    end else begin
                        result_d = falu_result;
                        flags_d  = {falu_exc, falu_ovf, falu_unf};
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end

            if (hs_c) begin
                state_d = IDLE;
                valid_d = 1'b0;
                op_d    = OP_IDLE;
                count_d = op_count + DATA_W'(1);
            end

            if (accept_c) begin
                state_d = EXEC;
                op_d    = io.in_op;
                a_d     = io.in_a;
                b_d     = io.in_b;
                rd_d    = io.in_rd;
                cnt_d   = lat_m1(io.in_op);
            end

            // Clear takes effect before the OR of a coincident handshake.
            if (flags_clr) begin
                sticky_d = hs_c ? io.out_flags : '0;
            end else if (hs_c) begin
                sticky_d = sticky_flags | io.out_flags;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            cnt           <= '0;
            falu_op       <= OP_IDLE;
            falu_a        <= '0;
            falu_b        <= '0;
            rd_q          <= '0;
            io.out_valid  <= 1'b0;
            io.out_result <= '0;
            io.out_rd     <= '0;
            io.out_flags  <= '0;
            sticky_flags  <= '0;
            op_count      <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            falu_op       <= op_d;
            falu_a        <= a_d;
            falu_b        <= b_d;
            rd_q          <= rd_d;
            io.out_valid  <= valid_d;
            io.out_result <= result_d;
            io.out_rd     <= out_rd_d;
            io.out_flags  <= flags_d;
            sticky_flags  <= sticky_d;
            op_count      <= count_d;
        end
    end
endmodule
